setbit_iter: RTL and testbench

Sequential set-bit iterator: accepts a WIDTH-bit vector over a valid/ready handshake and emits the index of every set bit, one index per output beat. Order is lowest-index-first or highest-index-first, selected by MODE. It is the streaming successor of the combinational leading/trailing-zero counter. It feeds schedulers and interrupt/request dispatch logic that must service every asserted request, not only the first one.

---
 rtl/setbit_iter_if.sv | 28 ++
 rtl/setbit_iter.sv | 112 +++++++++++
 tb/tb_setbit_iter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/setbit_iter_if.sv
// Handshake bundle for setbit_iter: vector input stream and per-index output stream.
// The DUT takes the slave modport; the producer/consumer side takes master.
interface setbit_iter_if #(
    parameter int WIDTH = 32
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] in_data_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [IDX_W-1:0] idx_o;
    logic [CNT_W-1:0] count_o;
    logic             last_o;
    logic             empty_o;
    logic             out_valid_o;
    logic             out_ready_i;

    modport slave (
        input  in_data_i, in_valid_i, out_ready_i,
        output in_ready_o, idx_o, count_o, last_o, empty_o, out_valid_o
    );

    modport master (
        output in_data_i, in_valid_i, out_ready_i,
        input  in_ready_o, idx_o, count_o, last_o, empty_o, out_valid_o
    );
endinterface

// File: rtl/setbit_iter.sv
// Streaming set-bit iterator: captures a vector, then emits the index of every
// set bit one per beat, lowest-first (MODE=0) or highest-first (MODE=1).
module setbit_iter #(
    parameter int WIDTH = 32,
    parameter int MODE  = 0
) (
    input  logic         clk_i,
    input  logic         arst_ni,
    input  logic         flush_i,
    setbit_iter_if.slave bus
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = $clog2(WIDTH + 1);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $fatal(1, "setbit_iter: WIDTH must be >= 1");
        end
        if (MODE != 0 && MODE != 1) begin : g_bad_mode
            $fatal(1, "setbit_iter: MODE must be 0 or 1");
        end
    endgenerate

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero_q, zero_d;

    // Later loop iterations override earlier ones, so the scan direction sets priority.
    function automatic logic [IDX_W-1:0] find_first(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        if (MODE == 0) begin
            for (int i = WIDTH - 1; i >= 0; i--)
                if (v[i]) r = IDX_W'(i);
        end else begin
            for (int i = 0; i < WIDTH; i++)
                if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++)
            c = c + CNT_W'(v[i]);
        return c;
    endfunction

    function automatic logic at_most_one(input logic [WIDTH-1:0] v);
        return (v & (v - WIDTH'(1))) == '0;
    endfunction

    logic             scan;
    logic [IDX_W-1:0] idx_cur;
    logic             last_cur;
    logic             out_hs;
    logic             in_hs;

    assign scan     = (state_q == SCAN);
    assign idx_cur  = find_first(work_q);
    assign last_cur = scan && at_most_one(work_q);
    assign out_hs   = scan && bus.out_ready_i;
    assign in_hs    = bus.in_valid_i && bus.in_ready_o;

    assign bus.out_valid_o = scan;
    assign bus.idx_o       = idx_cur;
    assign bus.count_o     = cnt_q;
    assign bus.last_o      = last_cur;
    assign bus.empty_o     = scan && zero_q;
    // Accepting on the final beat lets a new vector follow with no idle cycle.
    assign bus.in_ready_o  = !flush_i && (!scan || (last_cur && bus.out_ready_i));

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        if (flush_i) begin
            state_d = IDLE;
            work_d  = '0;
        end else begin
            if (out_hs) begin
                work_d[idx_cur] = 1'b0;
                if (last_cur) state_d = IDLE;
            end
            if (in_hs) begin
                state_d = SCAN;
                work_d  = bus.in_data_i;
                cnt_d   = popcount(bus.in_data_i);
                zero_d  = (bus.in_data_i == '0);
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
        end
    end
endmodule

// File: tb/tb_setbit_iter.sv
// Bench for setbit_iter: MODE=0 and MODE=1 instances share stimulus; each has
// its own expected-beat queue filled on input acceptance and drained by a monitor.
module tb_setbit_iter;
    localparam int W = 8;

    typedef struct {
        int idx;
        int cnt;
        bit last;
        bit empty;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] in_data = '0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic man_flush = 1'b0;
    logic rnd_flush = 1'b0;
    logic flush;
    assign flush = man_flush | rnd_flush;

    int rdy_mode = 0;
    int phase_cnt = 0;
    int vec_cnt = 0;
    int cmp_cnt = 0;
    int fails = 0;

    beat_t sbq[2][$];

    setbit_iter_if #(.WIDTH(W)) bus0 ();
    setbit_iter_if #(.WIDTH(W)) bus1 ();

    assign bus0.in_data_i   = in_data;
    assign bus0.in_valid_i  = in_valid;
    assign bus0.out_ready_i = out_ready;
    assign bus1.in_data_i   = in_data;
    assign bus1.in_valid_i  = in_valid;
    assign bus1.out_ready_i = out_ready;

    setbit_iter #(.WIDTH(W), .MODE(0)) u_lo (
        .clk_i(clk), .arst_ni(rst_n), .flush_i(flush), .bus(bus0)
    );
    setbit_iter #(.WIDTH(W), .MODE(1)) u_hi (
        .clk_i(clk), .arst_ni(rst_n), .flush_i(flush), .bus(bus1)
    );

    logic ov[2], ir[2], lst[2], emp[2];
    int   idxv[2], cntv[2];
    assign ov[0]   = bus0.out_valid_o;
    assign ov[1]   = bus1.out_valid_o;
    assign ir[0]   = bus0.in_ready_o;
    assign ir[1]   = bus1.in_ready_o;
    assign lst[0]  = bus0.last_o;
    assign lst[1]  = bus1.last_o;
    assign emp[0]  = bus0.empty_o;
    assign emp[1]  = bus1.empty_o;
    assign idxv[0] = int'(bus0.idx_o);
    assign idxv[1] = int'(bus1.idx_o);
    assign cntv[0] = int'(bus0.count_o);
    assign cntv[1] = int'(bus1.count_o);

    task automatic chk(input string name, input int act, input int exp);
        cmp_cnt++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: list set indices in the requested order; all-zero gives one marker beat.
    task automatic push_vec(input int m, input logic [W-1:0] v);
        int ids[$];
        for (int i = 0; i < W; i++)
            if (v[i]) ids.push_back(i);
        if (m == 1) ids.reverse();
        if (ids.size() == 0) begin
            sbq[m].push_back('{idx: 0, cnt: 0, last: 1'b1, empty: 1'b1});
        end else begin
            for (int k = 0; k < ids.size(); k++)
                sbq[m].push_back('{idx: ids[k], cnt: ids.size(),
                                   last: (k == ids.size() - 1), empty: 1'b0});
        end
    endtask

    task automatic mon(input int m);
        beat_t b;
        int exp_rdy;
        if (!rst_n) begin
            sbq[m].delete();
            chk($sformatf("rst_valid%0d", m), int'(ov[m]), 0);
            chk($sformatf("rst_idx%0d", m), idxv[m], 0);
            chk($sformatf("rst_count%0d", m), cntv[m], 0);
            chk($sformatf("rst_last%0d", m), int'(lst[m]), 0);
            chk($sformatf("rst_empty%0d", m), int'(emp[m]), 0);
            chk($sformatf("rst_in_ready%0d", m), int'(ir[m]), int'(!flush));
            return;
        end
        chk($sformatf("out_valid%0d", m), int'(ov[m]), int'(sbq[m].size() != 0));
        exp_rdy = int'(!flush && (sbq[m].size() == 0 || (sbq[m].size() == 1 && out_ready)));
        chk($sformatf("in_ready%0d", m), int'(ir[m]), exp_rdy);
        if (ov[m] && sbq[m].size() != 0) begin
            b = sbq[m][0];
            chk($sformatf("idx%0d", m), idxv[m], b.idx);
            chk($sformatf("count%0d", m), cntv[m], b.cnt);
            chk($sformatf("last%0d", m), int'(lst[m]), int'(b.last));
            chk($sformatf("empty%0d", m), int'(emp[m]), int'(b.empty));
        end
        if (flush) begin
            sbq[m].delete();
        end else begin
            if (ov[m] && out_ready && sbq[m].size() != 0) void'(sbq[m].pop_front());
            if (in_valid && ir[m]) begin
                push_vec(m, in_data);
                if (m == 0) vec_cnt++;
            end
        end
    endtask

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) mon(m);
    end

    // Output backpressure and random flush generator.
    always @(posedge clk) begin
        #1;
        phase_cnt++;
        case (rdy_mode)
            1: begin out_ready = (phase_cnt % 3 == 0); rnd_flush = 1'b0; end
            2: begin
                out_ready = 1'($urandom_range(0, 1));
                rnd_flush = ($urandom_range(0, 39) == 0);
            end
            default: begin out_ready = 1'b1; rnd_flush = 1'b0; end
        endcase
    end

    task automatic send(input logic [W-1:0] v);
        bit ok;
        ok = 1'b0;
        in_data  = v;
        in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (ir[0]) begin ok = 1'b1; break; end
        end
        chk("send_accept", int'(ok), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = W'($urandom);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(posedge clk);
            #2;
            if (sbq[0].size() == 0 && sbq[1].size() == 0 && !ov[0] && !ov[1]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain", int'(ok), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(8'b1010_0110);
        drain();

        send(8'h00);
        drain();

        send(8'h81);
        send(8'h10);
        drain();

        rdy_mode = 1;
        send(8'hFF);
        drain();
        rdy_mode = 0;
        @(posedge clk);
        #1;

        send(8'hF0);
        @(posedge clk);
        @(posedge clk);
        #1 man_flush = 1'b1;
        @(posedge clk);
        #1 man_flush = 1'b0;
        drain();
        send(8'h01);
        drain();

        send(8'hFF);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid0", int'(ov[0]), 0);
        chk("async_rst_valid1", int'(ov[1]), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        drain();
        send(8'h01);
        drain();

        rdy_mode = 2;
        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] v;
            v = W'($urandom);
            if ($urandom_range(0, 9) == 0) v = '0;
            send(v);
        end
        rdy_mode = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fails);
        $finish;
    end
endmodule
